// File: rtl/gpio_in_pkg.sv
// Shared definitions for the GPIO input block: byte offsets of the register map.
package gpio_in_pkg;

  localparam logic [4:0] OFS_DATA     = 5'h00;
  localparam logic [4:0] OFS_RISE_EN  = 5'h04;
  localparam logic [4:0] OFS_FALL_EN  = 5'h08;
  localparam logic [4:0] OFS_STATUS   = 5'h0C;
  localparam logic [4:0] OFS_DEBOUNCE = 5'h10;
  localparam logic [4:0] OFS_IRQ_EN   = 5'h14;

endpackage

// File: rtl/gpio_in_sync.sv
// Multi-stage flop chain bringing asynchronous pins into the clk domain.
module gpio_in_sync #(
  parameter int unsigned NPINS  = 28,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NPINS-1:0] d,
  output logic [NPINS-1:0] q
);

  logic [NPINS-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_input_28pins.sv
// Memory-mapped GPIO input peripheral: sync, debounce, sticky edge events, irq and read mux.
module gpio_input_28pins
  import gpio_in_pkg::*;
#(
  parameter int unsigned NPINS       = 28,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IOAdr,
  input  logic [31:0]      WriteIO,
  input  logic             IOWrite,
  output logic [31:0]      ReadIO,
  input  logic [NPINS-1:0] pins_in,
  output logic             irq
);

  logic [NPINS-1:0] sync;
  logic [NPINS-1:0] db_q, db_d;
  logic [NPINS-1:0] samp_q, samp_d;
  logic [NPINS-1:0] rise_en_q, rise_en_d;
  logic [NPINS-1:0] fall_en_q, fall_en_d;
  logic [NPINS-1:0] status_q, status_d;
  logic [NPINS-1:0] irq_en_q, irq_en_d;
  logic [DB_W-1:0]  deb_q, deb_d;
  logic [DB_W-1:0]  cnt_q, cnt_d;
  logic             irq_d;
  logic [NPINS-1:0] rise, fall, clr, stable;
  logic             tick;
  logic [4:0]       word_adr;
  logic             wr_rise, wr_fall, wr_status, wr_deb, wr_irq_en;
  logic             unused_bits;

  gpio_in_sync #(
    .NPINS  (NPINS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pins_in),
    .q     (sync)
  );

  // Byte-lane bits of the address and store data above the register width carry no meaning.
  assign unused_bits = ^{IOAdr[1:0], WriteIO};

  assign word_adr  = {IOAdr[4:2], 2'b00};
  assign wr_rise   = IOWrite && (word_adr == OFS_RISE_EN);
  assign wr_fall   = IOWrite && (word_adr == OFS_FALL_EN);
  assign wr_status = IOWrite && (word_adr == OFS_STATUS);
  assign wr_deb    = IOWrite && (word_adr == OFS_DEBOUNCE);
  assign wr_irq_en = IOWrite && (word_adr == OFS_IRQ_EN);

  always_comb begin
    rise_en_d = wr_rise   ? WriteIO[NPINS-1:0] : rise_en_q;
    fall_en_d = wr_fall   ? WriteIO[NPINS-1:0] : fall_en_q;
    irq_en_d  = wr_irq_en ? WriteIO[NPINS-1:0] : irq_en_q;
    deb_d     = wr_deb    ? WriteIO[DB_W-1:0]  : deb_q;

    // Counter runs 0..N and wraps; the wrap is the sample tick.
    tick   = (cnt_q == deb_q);
    cnt_d  = tick ? '0 : cnt_q + DB_W'(1);
    samp_d = tick ? sync : samp_q;
    if (wr_deb) cnt_d = '0;

    // A bit is accepted only when the current tick agrees with the previous one.
    stable = ~(sync ^ samp_q);
    db_d   = db_q;
    if (deb_q == '0) begin
      db_d = sync;
    end else if (tick) begin
      db_d = (sync & stable) | (db_q & ~stable);
    end

    rise     = ~db_q & db_d & rise_en_q;
    fall     = db_q & ~db_d & fall_en_q;
    clr      = wr_status ? WriteIO[NPINS-1:0] : '0;
    status_d = (status_q & ~clr) | rise | fall;

    irq_d = |(status_q & irq_en_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_q      <= '0;
      samp_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_en_q  <= '0;
      deb_q     <= '0;
      cnt_q     <= '0;
      irq       <= 1'b0;
    end else begin
      db_q      <= db_d;
      samp_q    <= samp_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      irq_en_q  <= irq_en_d;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      irq       <= irq_d;
    end
  end

  always_comb begin
    ReadIO = '0;
    case (word_adr)
      OFS_DATA:     ReadIO[NPINS-1:0] = db_q;
      OFS_RISE_EN:  ReadIO[NPINS-1:0] = rise_en_q;
      OFS_FALL_EN:  ReadIO[NPINS-1:0] = fall_en_q;
      OFS_STATUS:   ReadIO[NPINS-1:0] = status_q;
      OFS_DEBOUNCE: ReadIO[DB_W-1:0]  = deb_q;
      OFS_IRQ_EN:   ReadIO[NPINS-1:0] = irq_en_q;
      default:      ReadIO = '0;
    endcase
  end

endmodule

// File: tb/tb_gpio_input_28pins.sv
// Directed bench for gpio_input_28pins with a cycle-level reference model checked every cycle.
module tb_gpio_input_28pins;

  localparam int NP = 28;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    IOAdr;
  logic [31:0]   WriteIO;
  logic          IOWrite;
  logic [31:0]   ReadIO;
  logic [NP-1:0] pins_in;
  logic          irq;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  gpio_input_28pins dut (
    .clk     (clk),
    .reset   (reset),
    .IOAdr   (IOAdr),
    .WriteIO (WriteIO),
    .IOWrite (IOWrite),
    .ReadIO  (ReadIO),
    .pins_in (pins_in),
    .irq     (irq)
  );

  always #10 clk = ~clk;

  // Reference model state
  logic [NP-1:0] m_db = '0, m_samp = '0, m_rise_en = '0, m_fall_en = '0;
  logic [NP-1:0] m_status = '0, m_irq_en = '0;
  logic [15:0]   m_deb = '0;
  logic          m_irq = 1'b0;
  int            phase = 0;
  logic [NP-1:0] hist[$];

  initial for (int i = 0; i < SS; i++) hist.push_back('0);

  always @(posedge clk) begin
    logic [NP-1:0] s, nd, rise, fall, clr;
    if (reset) begin
      m_db = '0; m_samp = '0; m_rise_en = '0; m_fall_en = '0;
      m_status = '0; m_irq_en = '0; m_deb = '0; m_irq = 1'b0; phase = 0;
      hist = {};
      for (int i = 0; i < SS; i++) hist.push_back('0);
    end else begin
      s  = hist[0];
      nd = m_db;
      if (m_deb == 0) begin
        nd = s;
      end else if ((phase % (int'(m_deb) + 1)) == int'(m_deb)) begin
        for (int i = 0; i < NP; i++) nd[i] = (s[i] == m_samp[i]) ? s[i] : m_db[i];
        m_samp = s;
      end
      rise  = ~m_db & nd & m_rise_en;
      fall  = m_db & ~nd & m_fall_en;
      clr   = (IOWrite && (IOAdr & 5'h1C) == 5'h0C) ? WriteIO[NP-1:0] : '0;
      m_irq = |(m_status & m_irq_en);
      m_status = (m_status & ~clr) | rise | fall;
      m_db  = nd;
      phase = phase + 1;
      if (IOWrite) begin
        case (IOAdr & 5'h1C)
          5'h04: m_rise_en = WriteIO[NP-1:0];
          5'h08: m_fall_en = WriteIO[NP-1:0];
          5'h10: begin m_deb = WriteIO[15:0]; phase = 0; end
          5'h14: m_irq_en = WriteIO[NP-1:0];
          default: ;
        endcase
      end
      hist.push_back(pins_in);
      void'(hist.pop_front());
    end
  end

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a & 5'h1C)
      5'h00:   return 32'(m_db);
      5'h04:   return 32'(m_rise_en);
      5'h08:   return 32'(m_fall_en);
      5'h0C:   return 32'(m_status);
      5'h10:   return 32'(m_deb);
      5'h14:   return 32'(m_irq_en);
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model ReadIO", ReadIO, m_read(IOAdr));
      chk("model irq", 32'(irq), 32'(m_irq));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    IOAdr = a; WriteIO = d; IOWrite = 1'b1;
    cyc();
    IOWrite = 1'b0; WriteIO = '0;
  endtask

  task automatic chkrd(input string nm, input logic [4:0] a, input logic [31:0] exp);
    IOAdr = a;
    #1;
    chk(nm, ReadIO, exp);
  endtask

  initial begin
    reset = 1'b1; pins_in = '1; IOAdr = '0; WriteIO = '0; IOWrite = 1'b0;

    // 1: reset with pins high, then DATA follows after the sync+db latency
    cyc();
    cmp_en = 1'b1;
    cyc();
    for (int a = 0; a < 32; a += 4) chkrd("reset read", 5'(a), 32'h0);
    chk("reset irq", 32'(irq), 32'h0);
    reset = 1'b0;
    cyc(); cyc();
    chkrd("data before latency", 5'h00, 32'h0);
    cyc();
    chkrd("data after 3 edges", 5'h00, 32'h0FFF_FFFF);

    // 2: rising edge event and irq timing, then W1C
    pins_in = '0;
    repeat (4) cyc();
    wr(5'h04, 32'h1);
    wr(5'h14, 32'h1);
    pins_in = 28'h1;
    cyc(); cyc();
    chkrd("data edge2", 5'h00, 32'h0);
    cyc();
    chkrd("data edge3", 5'h00, 32'h1);
    chkrd("status edge3", 5'h0C, 32'h1);
    chk("irq edge3", 32'(irq), 32'h0);
    cyc();
    chk("irq edge4", 32'(irq), 32'h1);
    wr(5'h0C, 32'h1);
    chkrd("status after w1c", 5'h0C, 32'h0);
    cyc();
    chk("irq after w1c", 32'(irq), 32'h0);

    // 3: W1C on the same edge a new rise lands
    pins_in = '0;
    repeat (4) cyc();
    pins_in = 28'h1;
    cyc(); cyc();
    wr(5'h0C, 32'h1);
    chkrd("collision status", 5'h0C, 32'h1);
    cyc();
    chk("collision irq", 32'(irq), 32'h1);
    wr(5'h0C, 32'h1);
    wr(5'h14, 32'h0);

    // 4: debounce N=3, glitch rejected, stable level accepted
    wr(5'h04, 32'h2);
    wr(5'h10, 32'h3);
    pins_in = 28'h3;
    repeat (3) cyc();
    pins_in = 28'h1;
    repeat (20) cyc();
    chkrd("glitch data", 5'h00, 32'h1);
    chkrd("glitch status", 5'h0C, 32'h0);
    wr(5'h04, 32'h0);
    wr(5'h08, 32'h2);
    pins_in = 28'h3;
    repeat (12) cyc();
    chkrd("debounced high", 5'h00, 32'h3);
    chkrd("fall-only no rise event", 5'h0C, 32'h0);
    pins_in = 28'h1;
    repeat (12) cyc();
    chkrd("debounced low", 5'h00, 32'h1);
    chkrd("fall event", 5'h0C, 32'h2);
    wr(5'h0C, 32'h2);
    wr(5'h08, 32'h0);

    // 5: register map boundaries
    wr(5'h04, 32'hFFFF_FFFF);
    chkrd("rise_en width", 5'h04, 32'h0FFF_FFFF);
    wr(5'h1C, 32'hFFFF_FFFF);
    chkrd("unmapped 0x1c", 5'h1C, 32'h0);
    chkrd("unmapped 0x18", 5'h18, 32'h0);
    wr(5'h00, 32'h0);
    chkrd("data write ignored", 5'h00, 32'h1);
    chkrd("debounce readback", 5'h10, 32'h3);
    chkrd("byte offset ignored", 5'h13, 32'h3);
    wr(5'h04, 32'h0);

    // 6: reset in the middle of a long debounce period
    wr(5'h10, 32'd100);
    for (int k = 0; k < 49; k++) begin
      pins_in = pins_in ^ 28'h4;
      cyc();
    end
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chkrd("mid reset data", 5'h00, 32'h0);
    chkrd("mid reset status", 5'h0C, 32'h0);
    chkrd("mid reset debounce", 5'h10, 32'h0);
    wr(5'h04, 32'h4);
    cyc(); cyc();
    chkrd("resume data", 5'h00, 32'h5);
    chkrd("resume rise event", 5'h0C, 32'h4);
    repeat (4) cyc();

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
